// File: rtl/aes_enc_round_engine_if.sv
// Handshake and key-stream bundle for aes_enc_round_engine.
//   in_valid/in_ready/pt_in     : plaintext transfer into the engine
//   out_valid/out_ready/ct_out  : ciphertext transfer out of the engine
//   key_start/key_step          : strobes to key_expansion (start_enc / ready_enc)
//   round_key                   : round key from key_expansion (key_enc)
//   busy                        : engine is anywhere but IDLE
// Modport slave is the engine side; master is the system / key block side.
interface aes_enc_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct_out;
    logic         key_start;
    logic         key_step;
    logic [127:0] round_key;
    logic         busy;

    modport slave (
        input  in_valid, pt_in, out_ready, round_key,
        output in_ready, out_valid, ct_out, key_start, key_step, busy
    );

    modport master (
        output in_valid, pt_in, out_ready, round_key,
        input  in_ready, out_valid, ct_out, key_start, key_step, busy
    );
endinterface

// File: rtl/aes_enc_round_engine.sv
// Iterative AES-128 encryption engine, one round per round-key fetch from key_expansion.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : aes_enc_round_engine_if.slave (plaintext in, ciphertext out, key strobes,
//          round key in, busy)
// KEY_LAT (1..4): cycles from the end of a key strobe cycle to the round-key sample.
module aes_enc_round_engine #(
    parameter int unsigned KEY_LAT = 1
) (
    input logic                  clk,
    input logic                  rst,
    aes_enc_round_engine_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StWait  = 3'd2,
        StLoad  = 3'd3,
        StStep  = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam logic [3:0] LastRound = 4'd10;
    // WAIT lasts KEY_LAT-1 cycles; the counter runs down to zero inclusive.
    localparam logic [1:0] WaitInit  = (KEY_LAT >= 2) ? 2'(KEY_LAT - 2) : 2'd0;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] s_box(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes, ShiftRows and (unless last) MixColumns; byte k = s[127-8k -: 8],
    // byte 4c+r is row r of column c.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) sb[k] = s_box(s[127-8*k -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = last ? sr[k] : mc[k];
        return res;
    endfunction

    state_e       state_q;
    logic [127:0] blk_q;
    logic [3:0]   round_q;
    logic [1:0]   wait_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         key_start_q;
    logic         key_step_q;
    logic         busy_q;
    logic [127:0] round_out;

    always_comb begin
        round_out = '0;
        if (round_q == 4'd0) begin
            round_out = blk_q ^ bus.round_key;
        end else begin
            round_out = enc_round(blk_q, round_q == LastRound) ^ bus.round_key;
        end
    end

    // All outputs are registers loaded on the transition into the cycle they belong to,
    // so the key strobes are clean single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            blk_q       <= '0;
            round_q     <= '0;
            wait_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            key_start_q <= 1'b0;
            key_step_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            key_start_q <= 1'b0;
            key_step_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    round_q    <= '0;
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        blk_q       <= bus.pt_in;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        key_start_q <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart, StStep: begin
                    wait_q  <= WaitInit;
                    state_q <= (KEY_LAT == 1) ? StLoad : StWait;
                end
                StWait: begin
                    if (wait_q == 2'd0) begin
                        state_q <= StLoad;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                StLoad: begin
                    blk_q <= round_out;
                    if (round_q == LastRound) begin
                        state_q <= StDone;
                    end else begin
                        round_q    <= round_q + 4'd1;
                        key_step_q <= 1'b1;
                        state_q    <= StStep;
                    end
                end
                StDone: begin
                    // out_valid trails DONE entry by one cycle (registered decode).
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ct_out    = blk_q;
    assign bus.key_start = key_start_q;
    assign bus.key_step  = key_step_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Directed bench for aes_enc_round_engine: FIPS-197 vectors on a KEY_LAT=1 and a
// KEY_LAT=3 instance, each fed by a table-driven key_expansion stand-in.
module tb_aes_enc_round_engine;

    localparam logic [127:0] C1Pt = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1Ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BPt  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BCt  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Junk = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         sel;      // 0: KEY_LAT=1 instance, 1: KEY_LAT=3 instance
    logic         keysel;   // 0: C.1 key, 1: App. B key
    logic         in_valid;
    logic         out_ready;
    logic [127:0] pt_in;

    logic [127:0] rk_tab [2][11];

    aes_enc_round_engine_if bus1 ();
    aes_enc_round_engine_if bus3 ();

    assign bus1.in_valid  = in_valid & ~sel;
    assign bus1.out_ready = out_ready & ~sel;
    assign bus1.pt_in     = pt_in;
    assign bus3.in_valid  = in_valid & sel;
    assign bus3.out_ready = out_ready & sel;
    assign bus3.pt_in     = pt_in;

    aes_enc_round_engine #(.KEY_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    aes_enc_round_engine #(.KEY_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    // Key block stand-in: pointer moves on the strobe edge, key visible KEY_LAT-1 later.
    int ptr1 = 0;
    int ptr3 = 0;
    int ph1  = 0;
    int ph2  = 0;
    always @(posedge clk) begin
        if (bus1.key_start) ptr1 <= 0;
        else if (bus1.key_step && ptr1 < 10) ptr1 <= ptr1 + 1;
        if (bus3.key_start) ptr3 <= 0;
        else if (bus3.key_step && ptr3 < 10) ptr3 <= ptr3 + 1;
        ph1 <= ptr3;
        ph2 <= ph1;
    end
    assign bus1.round_key = rk_tab[keysel][ptr1];
    assign bus3.round_key = rk_tab[keysel][ph2];

    logic         obs_in_ready, obs_out_valid, obs_ks, obs_kp, obs_busy;
    logic [127:0] obs_ct;
    assign obs_in_ready  = sel ? bus3.in_ready  : bus1.in_ready;
    assign obs_out_valid = sel ? bus3.out_valid : bus1.out_valid;
    assign obs_ks        = sel ? bus3.key_start : bus1.key_start;
    assign obs_kp        = sel ? bus3.key_step  : bus1.key_step;
    assign obs_busy      = sel ? bus3.busy      : bus1.busy;
    assign obs_ct        = sel ? bus3.ct_out    : bus1.ct_out;

    // Strobe monitor: running counts, read as differences by the checks.
    int   n_ks = 0;
    int   n_kp = 0;
    int   n_viol = 0;
    logic prev_ks = 1'b0;
    logic prev_kp = 1'b0;
    always @(negedge clk) begin
        if (obs_ks) n_ks <= n_ks + 1;
        if (obs_kp) n_kp <= n_kp + 1;
        if ((obs_ks && obs_kp) || ((obs_ks || obs_kp) && (prev_ks || prev_kp)))
            n_viol <= n_viol + 1;
        prev_ks <= obs_ks;
        prev_kp <= obs_kp;
    end

    int n_vec = 0;
    int n_err = 0;
    int base_ks, base_kp, base_v;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        base_ks = n_ks;
        base_kp = n_kp;
        base_v  = n_viol;
    endtask

    task automatic send(input logic [127:0] pt);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        pt_in    = pt;
        while (!obs_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", obs_in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mark();
    endtask

    task automatic collect(input string tag, input logic [127:0] exp_ct, input int exp_lat);
        int lat = 0;
        while (!obs_out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ct"}, obs_ct, exp_ct);
        check({tag, "_nstart"}, n_ks - base_ks, 1);
        check({tag, "_nstep"}, n_kp - base_kp, 10);
        check({tag, "_strobe_rules"}, n_viol - base_v, 0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_oval_drop"}, obs_out_valid, 0);
        check({tag, "_in_ready"}, obs_in_ready, 1);
        check({tag, "_busy"}, obs_busy, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, obs_in_ready, 0);
        check({tag, "_out_valid"}, obs_out_valid, 0);
        check({tag, "_ct"}, obs_ct, 0);
        check({tag, "_key_start"}, obs_ks, 0);
        check({tag, "_key_step"}, obs_kp, 0);
        check({tag, "_busy"}, obs_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rk_tab[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tab[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_tab[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_tab[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_tab[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_tab[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_tab[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_tab[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_tab[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_tab[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_tab[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rk_tab[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; sel = 1'b0; keysel = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; pt_in = '0;
        @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_in_ready", obs_in_ready, 1);

        // FIPS-197 C.1, latency 1+11*2
        send(C1Pt);
        collect("c1", C1Ct, 23);
        drain("c1");

        // App. B twice in a row
        keysel = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(BPt);
            collect($sformatf("appb%0d", i), BCt, 23);
            drain($sformatf("appb%0d", i));
        end

        // Backpressure with a competing request held on in_valid
        send(BPt);
        collect("bp", BCt, 23);
        @(negedge clk);
        in_valid = 1'b1;
        pt_in    = Junk;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_ct", i), obs_ct, BCt);
            check($sformatf("bp_hold%0d_in_ready", i), obs_in_ready, 0);
            check($sformatf("bp_hold%0d_out_valid", i), obs_out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_hs_out_valid", obs_out_valid, 0);
        check("bp_hs_not_accepted", obs_busy, 0);
        check("bp_hs_in_ready", obs_in_ready, 1);
        @(negedge clk);
        pt_in = BPt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mark();
        check("bp_accept_busy", obs_busy, 1);
        collect("bp_next", BCt, 23);
        drain("bp_next");

        // Reset around round 5, then a clean C.1 block
        keysel = 1'b0;
        send(C1Pt);
        for (int g = 0; g < 100 && (n_kp - base_kp) < 5; g++) @(negedge clk);
        check("midrst_reached_round5", (n_kp - base_kp) >= 5, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        send(C1Pt);
        collect("c1_after_rst", C1Ct, 23);
        drain("c1_after_rst");

        // KEY_LAT=3 instance, latency 1+11*4
        sel = 1'b1;
        send(C1Pt);
        collect("c1_lat3", C1Ct, 45);
        drain("c1_lat3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
